// File: rtl/jt51_i2s_clkgen.sv
// Bit-clock divider and frame bit counter for jt51_i2s_tx. fall_stb marks the clk cycle
// whose edge produces a bclk falling edge; frame_stb marks the one that also wraps bit_cnt.
`include "jt51_i2s_defs.sv"

module jt51_i2s_clkgen #(
    parameter int W        = `JT51_I2S_W,
    parameter int BCLK_DIV = `JT51_I2S_BCLK_DIV,
    localparam int CNT_W   = `JT51_I2S_CNT_W(W)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             bclk,
    output logic             fall_stb,
    output logic             frame_stb,
    output logic [CNT_W-1:0] bit_cnt
);
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [CNT_W-1:0] BIT_MAX  = CNT_W'(`JT51_I2S_FRAME_BITS(W) - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] bit_nxt;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        div_nxt   = div_cnt + 1'b1;
        bit_nxt   = bit_cnt + 1'b1;
        fall_stb  = (div_cnt == DIV_MAX);
        frame_stb = 1'b0;
        if (fall_stb)
            div_nxt = '0;
        if (bit_cnt == BIT_MAX) begin
            bit_nxt   = '0;
            frame_stb = fall_stb;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            if (fall_stb)
                bit_cnt <= bit_nxt;
        end
    end

endmodule

// File: rtl/jt51_i2s_defs.sv
// Shared defaults for the JT51 I2S transmitter: sample width, bclk divider, frame size
// and bit-counter width. Included by the RTL and the bench.
`ifndef JT51_I2S_DEFS_VH
`define JT51_I2S_DEFS_VH

`define JT51_I2S_W               16
`define JT51_I2S_BCLK_DIV        4
`define JT51_I2S_FRAME_BITS(w)   (2*(w))
`define JT51_I2S_CNT_W(w)        $clog2(2*(w))

`endif

// File: rtl/jt51_i2s_tx.sv
// JT51 serial audio transmitter: double-buffered stereo capture, MSB-first shifter and
// word-select decode. Define JT51_I2S_LJ_EN for left-justified framing (default Philips I2S).
`include "jt51_i2s_defs.sv"

module jt51_i2s_tx #(
    parameter int W        = `JT51_I2S_W,
    parameter int BCLK_DIV = `JT51_I2S_BCLK_DIV
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_stb,
    input  logic [W-1:0] din_left,
    input  logic [W-1:0] din_right,
    output logic         bclk,
    output logic         lrclk,
    output logic         sdata,
    output logic         frame_start,
    output logic         ovr,
    output logic         und
);
    localparam int FRAME_BITS = `JT51_I2S_FRAME_BITS(W);
    localparam int CNT_W      = `JT51_I2S_CNT_W(W);

    if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_div
        $error("jt51_i2s_tx: BCLK_DIV must be even and >= 2");
    end

    logic                  fall_stb;
    logic                  frame_stb;
    logic [CNT_W-1:0]      bit_cnt;
    logic [W-1:0]          hold_l;
    logic [W-1:0]          hold_r;
    logic                  valid;
    logic [FRAME_BITS-1:0] shift_q;

    jt51_i2s_clkgen #(
        .W        (W),
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .bclk      (bclk),
        .fall_stb  (fall_stb),
        .frame_stb (frame_stb),
        .bit_cnt   (bit_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the hold buffer is reset too, since the first frame after reset must send zeros.
            hold_l      <= '0;
            hold_r      <= '0;
            valid       <= 1'b0;
            shift_q     <= '0;
            frame_start <= 1'b0;
            ovr         <= 1'b0;
            und         <= 1'b0;
        end else begin
            frame_start <= frame_stb;
            ovr         <= sample_stb && valid && !frame_stb;
            und         <= frame_stb && !valid && !sample_stb;

            if (sample_stb) begin
                hold_l <= din_left;
                hold_r <= din_right;
            end

            // A strobe on the load cycle is consumed by that same frame, so valid stays clear.
            if (frame_stb)
                valid <= 1'b0;
            else if (sample_stb)
                valid <= 1'b1;

            if (frame_stb)
                shift_q <= sample_stb ? {din_left, din_right} : {hold_l, hold_r};
            else if (fall_stb)
                shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign sdata = shift_q[FRAME_BITS-1];

`ifdef JT51_I2S_LJ_EN
    always_comb begin
        lrclk = (bit_cnt >= CNT_W'(W));
    end
`else
    localparam logic [CNT_W-1:0] BIT_MAX = CNT_W'(FRAME_BITS - 1);
    logic [CNT_W-1:0] bit_ahead;

    // Word select looks one bit ahead so it toggles one bclk before each MSB.
    always_comb begin
        bit_ahead = bit_cnt + 1'b1;
        if (bit_cnt == BIT_MAX)
            bit_ahead = '0;
        lrclk = (bit_ahead >= CNT_W'(W));
    end
`endif

endmodule
